ksa: RTL and testbench
======================

// Module: ksa
// PURPOSE
// - RC4 key-scheduling stage; runs directly after init, which leaves S[i]=i in the 256x8 S-RAM.
// - For i=0..255: j=(j+S[i]+key[i mod KEY_BYTES]) mod 256, then swap S[i] and S[j].
// - Shares the S-RAM port with init through a top-level mux. Started via the rdy/en handshake.
// PARAMETERS
// - KEY_BYTES  3  key length in bytes; key width = 8*KEY_BYTES; byte 0 = key[8*KEY_BYTES-1 -: 8]
// PORTS
// - clk      in   1             single clock; all logic on posedge
// - rst_n    in   1             synchronous, active-low reset
// - en       in   1             start request; honoured only while rdy=1
// - rdy      out  1             1 = idle, will accept en
// - key      in   8*KEY_BYTES   cipher key; sampled on the accepted-en cycle
// - addr     out  8             S-RAM address
// - rddata   in   8             S-RAM read data; valid the cycle after addr is presented
// - wrdata   out  8             S-RAM write data
// - wren     out  1             S-RAM write enable
// BEHAVIOUR
// - Reset values: rdy=1, wren=0, addr=0, wrdata=0; internal i=0, j=0, key-index=0, state=IDLE.
// - Handshake: en=1 && rdy=1 at a posedge latches key, clears i/j, enters RDI. rdy=0 from the next cycle.
// - en while rdy=0 is ignored.
// - FSM, one cycle per state:
//   IDLE: rdy=1.
//   RDI: addr=i.
//   WTI: latch si=rddata; j<=j+si+kb, 8-bit wrap.
//   RDJ: addr=j.
//   WTJ: latch sj=rddata.
//   WRI: addr=i, wrdata=sj, wren=1.
//   WRJ: addr=j, wrdata=si, wren=1; i<=i+1; key-index<=(key-index==KEY_BYTES-1)?0:key-index+1.
//   From WRJ: if i==255 -> IDLE, else -> RDI.
// - kb = key byte selected by the key-index counter. No divide/modulo hardware.
// - Latency: 6 cycles/iteration, 1536 cycles from accepted en to rdy=1.
// - New en is accepted on the first cycle rdy=1.
// - wren=1 only in WRI/WRJ; 0 in every other state.
// - i==j: both writes are still issued (same address, same data); the result is correct either way.
// - i wrap: the loop terminates on the i==255 compare before increment; i wraps to 0 in IDLE.
// - Reset mid-run: next posedge forces IDLE/reset values, wren=0 immediately.
//   S-RAM is left partially permuted; the top level must rerun init before re-enabling ksa.
// - addr/wrdata hold their last value when not writing; only wren qualifies a write.
// CONFIGURATION
// - KSA_SKIP_SELF_SWAP_EN defined: in RDJ, if new j==i, skip WTJ/WRI/WRJ.
//   Perform the i/key-index update and go to RDI or IDLE directly; that iteration takes 3 cycles, no wren.
// - Undefined: fixed 6-cycle iteration, as above.
// - Final S contents are identical in both builds.
// STRUCTURE
// - Package arc4_pkg:
//   - ksa_state_t enum (IDLE,RDI,WTI,RDJ,WTJ,WRI,WRJ)
//   - constants SBOX_N=256, SBOX_AW=8, BYTE_W=8
//   - shared with init and the later PRGA stage.
// - One sub-module: ksa_key_sel. Owns the mod-KEY_BYTES index counter (clear, advance) and outputs kb.
// - The main FSM and datapath (i, j, si, sj) stay in ksa.
// TESTING
// - The bench models the S-RAM as a behavioural 256x8 array with 1-cycle read latency, preloaded S[i]=i.
// - Reset/idle: rst_n=0 two cycles -> rdy=1, wren=0, addr=0. en asserted during reset -> no start.
// - key=24'h000000, en pulse -> iteration i=2 writes S[2]=3 then S[3]=2; iteration i=3 writes S[3]=5, S[5]=2.
// - key=24'h00033C, full run -> rdy rises exactly 1536 cycles after en; final S equals golden model;
//   S is a permutation of 0..255 (each value once).
// - Mid-run reset: rst_n=0 for 1 cycle at cycle 700 -> wren=0 and rdy=1 the next cycle.
//   After re-preload plus en, the final S matches golden.
// - en held high throughout a run -> no restart while rdy=0; a second run starts on the first rdy=1 cycle.
// - KSA_SKIP_SELF_SWAP_EN, key=24'h000000 -> iterations i=0 and i=1 take 3 cycles with no wren;
//   total cycles = 1536 - 3*(#self-swaps from golden); final S identical to the non-macro build.

Source files
------------

// File: rtl/arc4_pkg.sv
// Types and constants shared by the ARC4 init, key-scheduling and PRGA stages.
package arc4_pkg;

  localparam int SBOX_N  = 256;
  localparam int SBOX_AW = 8;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    RDI,
    WTI,
    RDJ,
    WTJ,
    WRI,
    WRJ
  } ksa_state_t;

endpackage

// File: rtl/ksa_key_sel.sv
// Key register and mod-KEY_BYTES byte index for the key-scheduling stage.
// The index wraps by compare, so no divider is needed.
module ksa_key_sel
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic                        adv,
  input  logic [BYTE_W*KEY_BYTES-1:0] key,
  output logic [BYTE_W-1:0]           kb
);

  localparam int IW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  logic [IW-1:0]               idx;
  logic [BYTE_W*KEY_BYTES-1:0] key_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      key_q <= '0;
    end else if (load) begin
      idx   <= '0;
      key_q <= key;
    end else if (adv) begin
      idx <= (idx == IW'(KEY_BYTES - 1)) ? '0 : idx + IW'(1);
    end
  end

  // Byte 0 is the most significant byte of the key.
  always_comb begin
    kb = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (idx == IW'(b)) kb = key_q[BYTE_W*(KEY_BYTES-1-b) +: BYTE_W];
    end
  end

endmodule

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes the S-RAM left as S[i]=i by init.
// Build option KSA_SKIP_SELF_SWAP_EN: skip the read/write-back when j==i.
module ksa
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic                        rdy,
  input  logic [BYTE_W*KEY_BYTES-1:0] key,
  output logic [SBOX_AW-1:0]          addr,
  input  logic [BYTE_W-1:0]           rddata,
  output logic [BYTE_W-1:0]           wrdata,
  output logic                        wren
);

  ksa_state_t          state, state_nxt;
  logic [SBOX_AW-1:0]  i, j, j_new, addr_nxt;
  logic [BYTE_W-1:0]   si, kb, wrdata_nxt;
  logic                wren_nxt, start, step, last;

  ksa_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start),
    .adv   (step),
    .key   (key),
    .kb    (kb)
  );

  assign rdy  = (state == IDLE);
  assign last = (i == SBOX_AW'(SBOX_N - 1));

  // Memory-facing outputs are registered: each is loaded on the transition
  // into the state that presents it, so it is stable for that whole cycle.
  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    wrdata_nxt = wrdata;
    wren_nxt   = 1'b0;
    start      = 1'b0;
    step       = 1'b0;
    j_new      = j + rddata + kb;
    case (state)
      IDLE: begin
        if (en) begin
          start     = 1'b1;
          state_nxt = RDI;
          addr_nxt  = '0;
        end
      end
      RDI: state_nxt = WTI;
      WTI: begin
        state_nxt = RDJ;
        addr_nxt  = j_new;
      end
      RDJ: begin
        state_nxt = WTJ;
`ifdef KSA_SKIP_SELF_SWAP_EN
        if (j == i) begin
          step      = 1'b1;
          state_nxt = last ? IDLE : RDI;
          if (!last) addr_nxt = i + 8'd1;
        end
`endif
      end
      // The wrdata register doubles as sj: S[j] goes straight into it.
      WTJ: begin
        state_nxt  = WRI;
        addr_nxt   = i;
        wrdata_nxt = rddata;
        wren_nxt   = 1'b1;
      end
      WRI: begin
        state_nxt  = WRJ;
        addr_nxt   = j;
        wrdata_nxt = si;
        wren_nxt   = 1'b1;
      end
      WRJ: begin
        step      = 1'b1;
        state_nxt = last ? IDLE : RDI;
        if (!last) addr_nxt = i + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      si     <= '0;
      addr   <= '0;
      wrdata <= '0;
      wren   <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      wrdata <= wrdata_nxt;
      wren   <= wren_nxt;
      if (start) begin
        i <= '0;
        j <= '0;
      end
      if (state == WTI) begin
        si <= rddata;
        j  <= j_new;
      end
      // i wraps 255 -> 0 on the final step, leaving it cleared in IDLE.
      if (step) i <= i + 8'd1;
    end
  end

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: behavioural S-RAM plus an RC4 KSA reference.
module tb_ksa;
  import arc4_pkg::*;

  localparam int KB = 3;

  typedef logic [7:0] sbox_t [256];

  logic          clk = 1'b0;
  logic          rst_n, en, rdy, wren, preload;
  logic [8*KB-1:0] key;
  logic [7:0]    addr, rddata, wrdata;
  sbox_t         mem;

  int total = 0;
  int bad   = 0;
  int obs_w[$];
  int exp_w[$];
  int first_w_cyc;

  always #5 clk = ~clk;

  ksa #(.KEY_BYTES(KB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  // 256x8 S-RAM, one-cycle read latency; preload restores the identity.
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Textbook key schedule; also lists the expected (addr,data) writes.
  function automatic sbox_t ref_ksa(input sbox_t s0, input logic [8*KB-1:0] k, output int selfs);
    sbox_t s;
    int jj, kbv;
    logic [7:0] tmp;
    s     = s0;
    jj    = 0;
    selfs = 0;
    exp_w.delete();
    for (int ii = 0; ii < 256; ii++) begin
      kbv = int'((k >> (8 * (KB - 1 - (ii % KB)))) & 24'hFF);
      jj  = (jj + int'(s[ii]) + kbv) % 256;
      if (ii == jj) selfs++;
`ifdef KSA_SKIP_SELF_SWAP_EN
      if (ii != jj)
`endif
      begin
        exp_w.push_back(ii * 256 + int'(s[jj]));
        exp_w.push_back(jj * 256 + int'(s[ii]));
      end
      tmp    = s[ii];
      s[ii]  = s[jj];
      s[jj]  = tmp;
    end
    return s;
  endfunction

  function automatic sbox_t identity();
    sbox_t s;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    return s;
  endfunction

  function automatic int exp_cycles(input int selfs);
`ifdef KSA_SKIP_SELF_SWAP_EN
    return 1536 - 3 * selfs;
`else
    return 1536 + 0 * selfs;
`endif
  endfunction

  function automatic int getw(input int idx);
    if (idx < obs_w.size()) return obs_w[idx];
    return -1;
  endfunction

  task automatic do_preload();
    @(negedge clk) preload = 1'b1;
    @(negedge clk) preload = 1'b0;
  endtask

  task automatic start(input logic [8*KB-1:0] k, input logic hold);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(posedge clk);
    #1 en = hold;
  endtask

  // Counts edges after the accepting edge until rdy is seen high.
  task automatic run(input int budget, output int cyc);
    bit done;
    obs_w.delete();
    first_w_cyc = -1;
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rdy) begin
        done = 1'b1;
      end else begin
        if (wren) begin
          if (first_w_cyc < 0) first_w_cyc = cyc;
          obs_w.push_back({16'h0, addr, wrdata});
        end
        @(posedge clk);
        cyc++;
        if (cyc > budget) begin
          @(negedge clk);
          check("run_timeout_rdy", {31'h0, rdy}, 32'h1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp_writes(input string tag);
    int nmis;
    int n;
    nmis = 0;
    n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
    for (int k = 0; k < n; k++) if (obs_w[k] != exp_w[k]) nmis++;
    check({tag, "_wr_count"}, obs_w.size(), exp_w.size());
    check({tag, "_wr_mismatches"}, nmis, 0);
  endtask

  task automatic cmp_sbox(input string tag, input sbox_t exp);
    int nmis;
    int seen [256];
    int dup;
    nmis = 0;
    dup  = 0;
    for (int k = 0; k < 256; k++) seen[k] = 0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== exp[k]) nmis++;
      seen[mem[k]]++;
    end
    for (int k = 0; k < 256; k++) if (seen[k] != 1) dup++;
    check({tag, "_sbox_mismatches"}, nmis, 0);
    check({tag, "_not_permutation"}, dup, 0);
  endtask

  initial begin
    sbox_t gold, gold2, start_s;
    int    selfs, selfs2, cyc, off;
    logic [8*KB-1:0] k1, k2;

    // Reset with en held high: must not start.
    rst_n = 1'b0; en = 1'b1; key = 24'hABCDEF; preload = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rdy", {31'h0, rdy}, 32'h1);
    check("reset_wren", {31'h0, wren}, 32'h0);
    check("reset_addr", {24'h0, addr}, 32'h0);
    rst_n = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_idle", {31'h0, rdy}, 32'h1);

    // All-zero key: early swaps are known by hand.
    do_preload();
    gold = ref_ksa(identity(), 24'h000000, selfs);
    start(24'h000000, 1'b0);
    run(3000, cyc);
    check("k0_cycles", cyc, exp_cycles(selfs));
`ifdef KSA_SKIP_SELF_SWAP_EN
    off = 0;
    check("k0_first_wr_cyc", first_w_cyc, 10);
`else
    off = 4;
    check("k0_first_wr_cyc", first_w_cyc, 4);
`endif
    check("k0_i2_write_si", getw(off + 0), {16'h0, 8'd2, 8'd3});
    check("k0_i2_write_sj", getw(off + 1), {16'h0, 8'd3, 8'd2});
    check("k0_i3_write_si", getw(off + 2), {16'h0, 8'd3, 8'd5});
    check("k0_i3_write_sj", getw(off + 3), {16'h0, 8'd5, 8'd2});
    cmp_writes("k0");
    cmp_sbox("k0", gold);

    // Key 00033C full run.
    do_preload();
    gold = ref_ksa(identity(), 24'h00033C, selfs);
    start(24'h00033C, 1'b0);
    run(3000, cyc);
    check("k33c_cycles", cyc, exp_cycles(selfs));
    check("k33c_idle_wren", {31'h0, wren}, 32'h0);
    cmp_writes("k33c");
    cmp_sbox("k33c", gold);

    // Random keys.
    for (int r = 0; r < 3; r++) begin
      k1 = 24'($urandom);
      do_preload();
      gold = ref_ksa(identity(), k1, selfs);
      start(k1, 1'b0);
      run(3000, cyc);
      check($sformatf("rand%0d_cycles", r), cyc, exp_cycles(selfs));
      cmp_writes($sformatf("rand%0d", r));
      cmp_sbox($sformatf("rand%0d", r), gold);
    end

    // Reset in the middle of a run, then a clean rerun.
    do_preload();
    start(24'h5A17C3, 1'b0);
    repeat (700) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_wren", {31'h0, wren}, 32'h0);
    check("midreset_rdy", {31'h0, rdy}, 32'h1);
    check("midreset_addr", {24'h0, addr}, 32'h0);
    rst_n = 1'b1;
    k1 = 24'($urandom);
    do_preload();
    gold = ref_ksa(identity(), k1, selfs);
    start(k1, 1'b0);
    run(3000, cyc);
    check("midreset_rerun_cycles", cyc, exp_cycles(selfs));
    cmp_sbox("midreset_rerun", gold);

    // en held high across a run: back-to-back start on the first rdy cycle.
    k1 = 24'($urandom);
    k2 = 24'($urandom);
    do_preload();
    gold = ref_ksa(identity(), k1, selfs);
    start(k1, 1'b1);
    run(3000, cyc);
    check("held_run1_cycles", cyc, exp_cycles(selfs));
    cmp_sbox("held_run1", gold);
    start_s = mem;
    key = k2;
    @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    check("held_restart_busy", {31'h0, rdy}, 32'h0);
    gold2 = ref_ksa(start_s, k2, selfs2);
    run(3000, cyc);
    check("held_run2_cycles", cyc + 1, exp_cycles(selfs2));
    cmp_sbox("held_run2", gold2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
